lfsr16_prbs_checker: RTL and testbench
======================================

// Module: lfsr16_prbs_checker
// PURPOSE
//  Receive-side partner of the 16-bit PRBS generator (Galois, x^16+x^5+x^3+x^2+1, serial out = MSB).
//  Takes the serial MSB bit stream, self-seeds from it, predicts each following bit, declares lock and counts bit errors.
//  Sits at the sink of any generator-driven link or test path, for link/BIST checking and game-RNG sanity checks.
// PARAMETERS
//  LOCK_CNT    32  consecutive correct predictions needed to enter LOCKED (range 1..255)
//  WINDOW      64  accepted-bit window length used for loss-of-lock detection (range 2..65535)
//  LOSS_THRESH 4   mismatches within one WINDOW that force re-seed (range 1..WINDOW)
//  ERR_W       16  width of ErrCount
// PORTS
//  Clk       in   1      rising-edge clock
//  Rst       in   1      synchronous reset, active-high
//  Din       in   1      received serial bit (generator MSB)
//  DinValid  in   1      Din is sampled only when high; low = stall, all state held
//  ClrCnt    in   1      synchronous clear of ErrCount
//  Locked    out  1      high while in LOCKED
//  ErrPulse  out  1      one-cycle pulse per mismatch detected in LOCKED
//  ErrCount  out  ERR_W  saturating mismatch count, LOCKED state only
//  ZeroSeed  out  1      high while the history is all zeros in SEED (stuck-at-0 input)
// BEHAVIOUR
//  - Reset: Hist=0, state SEED, SeedCnt=0, MatchCnt=0, WinCnt=0, WinErr=0; all outputs 0.
//  - Hist[15:0]: shift register, Hist[0] newest bit, Hist[15] oldest. Each accepted bit shifts in at Hist[0].
//  - Prediction: P = Hist[15]^Hist[13]^Hist[12]^Hist[10] (recurrence s[n+16]=s[n+5]^s[n+3]^s[n+2]^s[n]).
//  - Accepted bit = cycle with DinValid=1. No counter or state changes on non-accepted cycles.
//  - SEED: shift in Din and increment SeedCnt. After the 16th accepted bit:
//    Hist != 0 -> VERIFY, MatchCnt=0. Hist == 0 -> stay in SEED with SeedCnt held at 16 and ZeroSeed=1;
//    every further bit is shifted in and re-tested.
//  - VERIFY: shift in Din. Din==P -> MatchCnt++; at MatchCnt==LOCK_CNT -> LOCKED, WinCnt=WinErr=0.
//    Din!=P -> SEED, SeedCnt=0. Hist is kept; re-seeding still needs 16 fresh bits.
//  - LOCKED (flywheel): shift in P, never Din, so one corrupted bit counts as exactly one error.
//    Din!=P -> ErrPulse=1 next cycle, ErrCount++ (saturates at all-ones), WinErr++.
//    WinCnt++ on every accepted bit. If WinCnt reaches WINDOW-1 on this bit, WinCnt and WinErr both clear to 0.
//    Loss of lock: WinErr reaching LOSS_THRESH (this bit included) -> SEED, SeedCnt=0. This takes priority over the window wrap.
//  - Output latency: all outputs are registered. Locked rises/falls the cycle after the deciding bit is accepted.
//    ErrPulse appears the cycle after the bad bit.
//  - ErrCount changes only through Rst, ClrCnt or a LOCKED mismatch. It is held across loss of lock and re-lock.
//  - ClrCnt together with a mismatch in the same cycle: ClrCnt wins, so ErrCount=0. ErrPulse still fires, and WinErr still increments.
//  - Rst mid-stream: Rst overrides everything. Reset values apply the next cycle, even with DinValid=1.
//  - No all-zero lockup: LOCKED is entered only from a non-zero Hist, and the recurrence preserves non-zero.
// CONFIGURATION
//  LFSR16_CHK_BITCOUNT_EN defined:
//    - adds output BitCount[31:0]: count of bits accepted while LOCKED, saturating at 32'hFFFFFFFF;
//    - BitCount clears on Rst or ClrCnt and is held outside LOCKED;
//    - with ErrCount it gives the BER.
//  Macro undefined: no BitCount port and no counter logic. All other behaviour is identical.
// TESTING
//  1. Golden generator seeded 16'hFFFF, DinValid=1 every cycle -> Locked=1 exactly 1 cycle after bit 48 (16+LOCK_CNT); ErrCount=0 over 10000 bits.
//  2. Locked stream, invert a single bit -> exactly one ErrPulse cycle, ErrCount=1, Locked stays 1; following bits match.
//  3. Locked, invert 4 bits inside 64 accepted bits -> Locked=0 the cycle after 4th error, ErrCount=4; clean stream -> re-lock after 48 more bits.
//  4. Din=0 constant for 40 bits -> ZeroSeed=1 from bit 16 on, Locked=0, ErrCount=0; then golden stream -> ZeroSeed=0, lock achieved.
//  5. Golden stream with DinValid toggling pseudo-randomly (~50%) -> lock after 48 accepted bits, no errors; ClrCnt plus a mismatch in the same cycle -> ErrCount=0, ErrPulse=1.
//  6. Rst=1 for one cycle while locked -> next cycle Locked=0, ErrCount=0, state SEED; with LFSR16_CHK_BITCOUNT_EN, BitCount=1000 after 1000 locked bits.

Source files
------------

// File: rtl/lfsr16_prbs_checker.sv
// Purpose: self-seeding checker for the MSB-first x^16+x^5+x^3+x^2+1 PRBS; declares lock, counts bit errors.
// Latency: every output is registered and reflects the deciding accepted bit one cycle later.
// Backpressure: none; DinValid low stalls all state. Define LFSR16_CHK_BITCOUNT_EN to add the BitCount output.
module lfsr16_prbs_checker #(
  parameter int unsigned LOCK_CNT    = 32,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Din,
  input  logic             DinValid,
  input  logic             ClrCnt,
  output logic             Locked,
  output logic             ErrPulse,
  output logic [ERR_W-1:0] ErrCount,
  output logic             ZeroSeed
`ifdef LFSR16_CHK_BITCOUNT_EN
  ,
  output logic [31:0]      BitCount
`endif
);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [4:0]  SEED_LEN = 5'd16;
  localparam logic [7:0]  LOCK_C   = 8'(LOCK_CNT);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
  localparam logic [15:0] LOSS_C   = 16'(LOSS_THRESH);

  state_t           state_q, state_d;
  logic [15:0]      hist_q, hist_d;
  logic [4:0]       seed_cnt_q, seed_cnt_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [15:0]      win_cnt_q, win_cnt_d;
  logic [15:0]      win_err_q, win_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q, locked_d;
  logic             zero_seed_q, zero_seed_d;
`ifdef LFSR16_CHK_BITCOUNT_EN
  logic [31:0]      bit_cnt_q, bit_cnt_d;
`endif

  logic             pred;
  logic             bad;
  logic [7:0]       match_inc;
  logic [15:0]      win_inc;
  logic [15:0]      win_err_inc;

  // Hist[0] is the newest bit, so Hist[15]/[13]/[12]/[10] are s[n], s[n+2], s[n+3], s[n+5].
  assign pred        = hist_q[15] ^ hist_q[13] ^ hist_q[12] ^ hist_q[10];
  assign bad         = (Din != pred);
  assign match_inc   = match_cnt_q + 8'd1;
  assign win_inc     = win_cnt_q + 16'd1;
  assign win_err_inc = win_err_q + 16'd1;

  // Next-state, counter and output computation for seed / verify / flywheel-locked operation.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
`ifdef LFSR16_CHK_BITCOUNT_EN
    bit_cnt_d   = bit_cnt_q;
`endif

    if (DinValid) begin
      unique case (state_q)
        ST_SEED: begin
          hist_d = {hist_q[14:0], Din};
          if (seed_cnt_q != SEED_LEN) begin
            seed_cnt_d = seed_cnt_q + 5'd1;
          end
          // An all-zero history cannot predict anything; keep re-testing each new bit.
          if ((seed_cnt_d == SEED_LEN) && (hist_d != 16'h0000)) begin
            state_d     = ST_VERIFY;
            match_cnt_d = 8'd0;
          end
        end

        ST_VERIFY: begin
          hist_d = {hist_q[14:0], Din};
          if (!bad) begin
            match_cnt_d = match_inc;
            if (match_inc == LOCK_C) begin
              state_d   = ST_LOCKED;
              win_cnt_d = 16'd0;
              win_err_d = 16'd0;
            end
          end else begin
            // History is kept, but a fresh 16-bit seed is still required.
            state_d    = ST_SEED;
            seed_cnt_d = 5'd0;
          end
        end

        ST_LOCKED: begin
          // Flywheel: feed the prediction back so one corrupted bit is one error, not four.
          hist_d    = {hist_q[14:0], pred};
          win_cnt_d = win_inc;
          if (bad) begin
            err_pulse_d = 1'b1;
            win_err_d   = win_err_inc;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
          end
          // Loss of lock outranks the window wrap on the same bit.
          if (bad && (win_err_inc == LOSS_C)) begin
            state_d    = ST_SEED;
            seed_cnt_d = 5'd0;
          end else if (win_inc == WIN_LAST) begin
            win_cnt_d = 16'd0;
            win_err_d = 16'd0;
          end
        end

        default: begin
          state_d    = ST_SEED;
          seed_cnt_d = 5'd0;
        end
      endcase
    end

`ifdef LFSR16_CHK_BITCOUNT_EN
    if (DinValid && (state_q == ST_LOCKED) && (bit_cnt_q != 32'hFFFF_FFFF)) begin
      bit_cnt_d = bit_cnt_q + 32'd1;
    end
    if (ClrCnt) begin
      bit_cnt_d = 32'd0;
    end
`endif

    // Clear beats a same-cycle mismatch; the pulse and window error still register.
    if (ClrCnt) begin
      err_cnt_d = '0;
    end

    locked_d    = (state_d == ST_LOCKED);
    zero_seed_d = (state_d == ST_SEED) && (seed_cnt_d == SEED_LEN) && (hist_d == 16'h0000);
  end

  // State and registered outputs; synchronous reset overrides any accepted bit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_SEED;
      hist_q      <= 16'h0000;
      seed_cnt_q  <= 5'd0;
      match_cnt_q <= 8'd0;
      win_cnt_q   <= 16'd0;
      win_err_q   <= 16'd0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      zero_seed_q <= 1'b0;
`ifdef LFSR16_CHK_BITCOUNT_EN
      bit_cnt_q   <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
      zero_seed_q <= zero_seed_d;
`ifdef LFSR16_CHK_BITCOUNT_EN
      bit_cnt_q   <= bit_cnt_d;
`endif
    end
  end

  assign Locked   = locked_q;
  assign ErrPulse = err_pulse_q;
  assign ErrCount = err_cnt_q;
  assign ZeroSeed = zero_seed_q;
`ifdef LFSR16_CHK_BITCOUNT_EN
  assign BitCount = bit_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr16_prbs_checker.sv
// Bench for lfsr16_prbs_checker: directed bit streams from a Galois reference generator.
// Expected outputs are queued with the cycle they are due; a monitor pops and compares them.
// Runs a fixed number of cycles, so it always reaches its summary line.
module tb_lfsr16_prbs_checker;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Din;
  logic        DinValid;
  logic        ClrCnt;
  logic        Locked;
  logic        ErrPulse;
  logic [15:0] ErrCount;
  logic        ZeroSeed;
`ifdef LFSR16_CHK_BITCOUNT_EN
  logic [31:0] BitCount;
`endif

  always #5 Clk = ~Clk;

  lfsr16_prbs_checker #(
    .LOCK_CNT(32),
    .WINDOW(64),
    .LOSS_THRESH(4),
    .ERR_W(16)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Din(Din),
    .DinValid(DinValid),
    .ClrCnt(ClrCnt),
    .Locked(Locked),
    .ErrPulse(ErrPulse),
    .ErrCount(ErrCount),
    .ZeroSeed(ZeroSeed)
`ifdef LFSR16_CHK_BITCOUNT_EN
    ,
    .BitCount(BitCount)
`endif
  );

  typedef struct {
    int unsigned due;
    string       name;
    logic        locked;
    logic        pulse;
    logic [15:0] cnt;
    logic        zs;
    bit          chk_bc;
    logic [31:0] bc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned stim_cyc = 0;
  int unsigned mon_cyc  = 0;
  logic [15:0] gen_st;

  // Galois generator, left shift, feedback mask for x^5+x^3+x^2+1, serial out = MSB.
  task automatic gen_bit(output logic b);
    b      = gen_st[15];
    gen_st = {gen_st[14:0], 1'b0} ^ (gen_st[15] ? 16'h002D : 16'h0000);
  endtask

  // One stimulus cycle: inputs change on the falling edge, sampled on the next rising edge.
  task automatic drive(input logic d, input logic v, input logic c, input logic r);
    @(negedge Clk);
    stim_cyc++;
    Din      = d;
    DinValid = v;
    ClrCnt   = c;
    Rst      = r;
  endtask

  // Outputs expected one cycle after the most recent drive.
  task automatic expect_out(input string nm, input logic l, input logic p,
                            input logic [15:0] c, input logic z);
    exp_t e;
    e.due = stim_cyc + 1; e.name = nm; e.locked = l; e.pulse = p;
    e.cnt = c; e.zs = z; e.chk_bc = 1'b0; e.bc = 32'd0;
    sb_q.push_back(e);
  endtask

  task automatic expect_outb(input string nm, input logic l, input logic p,
                             input logic [15:0] c, input logic z, input logic [31:0] bc);
    exp_t e;
    e.due = stim_cyc + 1; e.name = nm; e.locked = l; e.pulse = p;
    e.cnt = c; e.zs = z; e.chk_bc = 1'b1; e.bc = bc;
    sb_q.push_back(e);
  endtask

  // Monitor: on each falling edge, compare every expectation that has come due.
  initial begin
    exp_t e;
    logic bc_bad;
    forever begin
      @(negedge Clk);
      mon_cyc++;
      while ((sb_q.size() > 0) && (sb_q[0].due <= mon_cyc)) begin
        e = sb_q.pop_front();
        n_checks++;
        bc_bad = 1'b0;
`ifdef LFSR16_CHK_BITCOUNT_EN
        if (e.chk_bc && (BitCount !== e.bc)) bc_bad = 1'b1;
        if (bc_bad) $display("FAIL %s: BitCount=%0d expected %0d", e.name, BitCount, e.bc);
`endif
        if ((e.due != mon_cyc) || (Locked !== e.locked) || (ErrPulse !== e.pulse) ||
            (ErrCount !== e.cnt) || (ZeroSeed !== e.zs) || bc_bad) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: Locked=%b ErrPulse=%b ErrCount=%0d ZeroSeed=%b, expected %b %b %0d %b",
                   e.name, mon_cyc, Locked, ErrPulse, ErrCount, ZeroSeed,
                   e.locked, e.pulse, e.cnt, e.zs);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    logic       b;
    int         acc;
    logic [7:0] vpat;
    Rst = 1'b1; Din = 1'b0; DinValid = 1'b0; ClrCnt = 1'b0;
    gen_st = 16'hFFFF;

    // Reset, including a cycle with DinValid high.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    expect_out("reset", 1'b0, 1'b0, 16'd0, 1'b0);

    // Golden stream from 16'hFFFF: lock exactly one cycle after bit 48.
    for (int i = 1; i <= 48; i++) begin
      gen_bit(b); drive(b, 1'b1, 1'b0, 1'b0);
      if (i == 16) expect_out("t1_seed_done", 1'b0, 1'b0, 16'd0, 1'b0);
      if (i == 47) expect_out("t1_prelock", 1'b0, 1'b0, 16'd0, 1'b0);
      if (i == 48) expect_out("t1_lock", 1'b1, 1'b0, 16'd0, 1'b0);
    end
    for (int i = 1; i <= 10000; i++) begin
      gen_bit(b); drive(b, 1'b1, 1'b0, 1'b0);
      if ((i % 2500) == 0) expect_out("t1_clean_run", 1'b1, 1'b0, 16'd0, 1'b0);
    end

    // Single inverted bit while locked (locked bit #10001).
    gen_bit(b); drive(~b, 1'b1, 1'b0, 1'b0);
    expect_out("t2_err", 1'b1, 1'b1, 16'd1, 1'b0);
    gen_bit(b); drive(b, 1'b1, 1'b0, 1'b0);
    expect_out("t2_next_ok", 1'b1, 1'b0, 16'd1, 1'b0);
    for (int i = 1; i <= 98; i++) begin
      gen_bit(b); drive(b, 1'b1, 1'b0, 1'b0);
      if (i == 98) expect_out("t2_clean", 1'b1, 1'b0, 16'd1, 1'b0);
    end

    // Clear on an idle cycle.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    expect_out("clr_idle", 1'b1, 1'b0, 16'd0, 1'b0);

    // Locked bits 10101..10107 all fall in the window 10081..10143: errors on odd steps.
    for (int i = 1; i <= 7; i++) begin
      gen_bit(b);
      if ((i % 2) == 1) begin
        drive(~b, 1'b1, 1'b0, 1'b0);
        if (i == 7) expect_out("t3_loss", 1'b0, 1'b1, 16'd4, 1'b0);
        else        expect_out("t3_err", 1'b1, 1'b1, 16'((i + 1) / 2), 1'b0);
      end else begin
        drive(b, 1'b1, 1'b0, 1'b0);
        expect_out("t3_gap", 1'b1, 1'b0, 16'(i / 2), 1'b0);
      end
    end
    for (int i = 1; i <= 48; i++) begin
      gen_bit(b); drive(b, 1'b1, 1'b0, 1'b0);
      if (i == 1)  expect_out("t3_reseed", 1'b0, 1'b0, 16'd4, 1'b0);
      if (i == 47) expect_out("t3_prelock", 1'b0, 1'b0, 16'd4, 1'b0);
      if (i == 48) expect_out("t3_relock", 1'b1, 1'b0, 16'd4, 1'b0);
    end

    // Reset while locked with a valid bit present.
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    expect_out("rst_locked", 1'b0, 1'b0, 16'd0, 1'b0);

    // Stuck-at-0 input: ZeroSeed from bit 16 on, a stall keeps it.
    for (int i = 1; i <= 40; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 15) expect_out("t4_zs_pre", 1'b0, 1'b0, 16'd0, 1'b0);
      if (i == 16) expect_out("t4_zs_on", 1'b0, 1'b0, 16'd0, 1'b1);
      if (i == 40) expect_out("t4_zs_hold", 1'b0, 1'b0, 16'd0, 1'b1);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("t4_zs_stall", 1'b0, 1'b0, 16'd0, 1'b1);
    // Golden bits 1,1: first leaves zero-seed, second breaks VERIFY; 16 seed + 32 checks follow.
    gen_st = 16'hFFFF;
    for (int i = 1; i <= 50; i++) begin
      gen_bit(b); drive(b, 1'b1, 1'b0, 1'b0);
      if (i == 1)  expect_out("t4_zs_off", 1'b0, 1'b0, 16'd0, 1'b0);
      if (i == 49) expect_out("t4_prelock", 1'b0, 1'b0, 16'd0, 1'b0);
      if (i == 50) expect_out("t4_lock", 1'b1, 1'b0, 16'd0, 1'b0);
    end

    // Reset while locked, then golden stream with gapped DinValid and junk on idle cycles.
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("t5_rst", 1'b0, 1'b0, 16'd0, 1'b0);
    gen_st = 16'hFFFF;
    acc    = 0;
    vpat   = 8'hB4;
    while (acc < 48) begin
      if (vpat[0]) begin
        gen_bit(b); acc++;
        drive(b, 1'b1, 1'b0, 1'b0);
        if (acc == 47) expect_out("t5_prelock", 1'b0, 1'b0, 16'd0, 1'b0);
        if (acc == 48) expect_out("t5_lock", 1'b1, 1'b0, 16'd0, 1'b0);
      end else begin
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      end
      vpat = {vpat[0], vpat[7:1]};
    end
    drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    expect_out("t5_stall", 1'b1, 1'b0, 16'd0, 1'b0);
    gen_bit(b); drive(~b, 1'b1, 1'b0, 1'b0);
    expect_out("t5_err", 1'b1, 1'b1, 16'd1, 1'b0);
    gen_bit(b); drive(b, 1'b1, 1'b0, 1'b0);
    expect_out("t5_ok", 1'b1, 1'b0, 16'd1, 1'b0);
    gen_bit(b); drive(~b, 1'b1, 1'b1, 1'b0);
    expect_out("t5_clr_vs_err", 1'b1, 1'b1, 16'd0, 1'b0);
    gen_bit(b); drive(b, 1'b1, 1'b0, 1'b0);
    expect_out("t5_after_clr", 1'b1, 1'b0, 16'd0, 1'b0);

    // Reset while locked, relock, then 1000 locked bits.
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    expect_outb("t6_rst", 1'b0, 1'b0, 16'd0, 1'b0, 32'd0);
    gen_st = 16'hFFFF;
    for (int i = 1; i <= 48; i++) begin
      gen_bit(b); drive(b, 1'b1, 1'b0, 1'b0);
      if (i == 48) expect_outb("t6_lock", 1'b1, 1'b0, 16'd0, 1'b0, 32'd0);
    end
    for (int i = 1; i <= 1000; i++) begin
      gen_bit(b); drive(b, 1'b1, 1'b0, 1'b0);
      if (i == 1000) expect_outb("t6_bits", 1'b1, 1'b0, 16'd0, 1'b0, 32'd1000);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    expect_outb("t6_hold", 1'b1, 1'b0, 16'd0, 1'b0, 32'd1000);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    expect_outb("t6_clr", 1'b1, 1'b0, 16'd0, 1'b0, 32'd0);

    // Drain and close.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
